// File: rtl/riscv_pkg.sv
// Shared encodings for the RV32I controllers: FSM states, opcodes, ALU and
// datapath-select codes, plus the opcode-driven decode helpers.
package riscv_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BEQ, JAL, FAULT
  } mc_state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  function automatic logic [1:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

  // Opcodes the core does not implement land in FAULT.
  function automatic mc_state_t decode_next(input logic [6:0] op);
    case (op)
      OP_LW, OP_SW: return MEMADR;
      OP_R:         return EXECR;
      OP_I:         return EXECI;
      OP_BEQ:       return BEQ;
      OP_JAL:       return JAL;
      default:      return FAULT;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Controller <-> datapath signal bundle: instruction fields and status in,
// selects and write enables out.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;

  logic       pc_write;
  logic       adr_src;
  logic       mem_write;
  logic       ir_write;
  logic       reg_write;
  logic [1:0] result_src;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] imm_src;
  logic [2:0] alu_control;
  logic       illegal;

  modport master (
    input  op, funct3, funct7b5, zero, mem_ready,
    output pc_write, adr_src, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal
  );

  modport slave (
    output op, funct3, funct7b5, zero, mem_ready,
    input  pc_write, adr_src, mem_write, ir_write, reg_write,
           result_src, alu_src_a, alu_src_b, imm_src, alu_control, illegal
  );
endinterface

// File: rtl/alu_decoder.sv
// Maps the coarse alu_op from a controller plus funct fields onto the ALU
// operation code; shared by the single-cycle and multicycle controllers.
module alu_decoder
  import riscv_pkg::*;
(
  input  alu_op_t    i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_op5,
  input  logic       i_funct7b5,
  output logic [2:0] o_alu_control
);

  always_comb begin
    // NOTE: default assignment first so every path drives the output and no latch is inferred.
    o_alu_control = ALU_ADD;
    case (i_alu_op)
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct3)
          3'b000:  o_alu_control = (i_op5 & i_funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  o_alu_control = ALU_SLT;
          3'b110:  o_alu_control = ALU_OR;
          3'b111:  o_alu_control = ALU_AND;
          default: o_alu_control = ALU_ADD;
        endcase
      end
      default: o_alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I sequencer: walks one instruction through fetch..writeback,
// stalls on mem_ready in memory states and parks in FAULT on unknown opcodes.
module multicycle_controller
  import riscv_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  multicycle_controller_if.master bus
);

  mc_state_t  r_state;
  alu_op_t    w_alu_op;
  logic [2:0] w_alu_control;

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments for state so every flop samples pre-edge values.
    if (reset) begin
      r_state <= FETCH;
    end else begin
      case (r_state)
        FETCH:       if (bus.mem_ready) r_state <= DECODE;
        DECODE:      r_state <= decode_next(bus.op);
        MEMADR:      r_state <= (bus.op == OP_SW) ? MEMWRITE : MEMREAD;
        MEMREAD:     if (bus.mem_ready) r_state <= MEMWB;
        MEMWB:       r_state <= FETCH;
        MEMWRITE:    if (bus.mem_ready) r_state <= FETCH;
        EXECR, EXECI: r_state <= ALUWB;
        ALUWB, BEQ:  r_state <= FETCH;
        JAL:         r_state <= ALUWB;
        FAULT:       r_state <= FAULT;
        default:     r_state <= FAULT;
      endcase
    end
  end

  // Outputs stay zero for the whole reset cycle so no write can slip through.
  always_comb begin
    bus.pc_write   = 1'b0;
    bus.adr_src    = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.reg_write  = 1'b0;
    bus.result_src = RES_ALUOUT;
    bus.alu_src_a  = SRCA_PC;
    bus.alu_src_b  = SRCB_RS2;
    bus.imm_src    = IMM_I;
    bus.illegal    = 1'b0;
    w_alu_op       = ALUOP_ADD;
    if (!reset) begin
      bus.imm_src = imm_src_of(bus.op);
      case (r_state)
        FETCH: begin
          bus.alu_src_a  = SRCA_PC;
          bus.alu_src_b  = SRCB_FOUR;
          bus.result_src = RES_ALU;
          bus.ir_write   = bus.mem_ready;
          bus.pc_write   = bus.mem_ready;
        end
        DECODE: begin
          bus.alu_src_a = SRCA_OLDPC;
          bus.alu_src_b = SRCB_IMM;
        end
        MEMADR: begin
          bus.alu_src_a = SRCA_RS1;
          bus.alu_src_b = SRCB_IMM;
        end
        MEMREAD: bus.adr_src = 1'b1;
        MEMWB: begin
          bus.result_src = RES_DATA;
          bus.reg_write  = 1'b1;
        end
        MEMWRITE: begin
          bus.adr_src   = 1'b1;
          bus.mem_write = 1'b1;
        end
        EXECR: begin
          bus.alu_src_a = SRCA_RS1;
          bus.alu_src_b = SRCB_RS2;
          w_alu_op      = ALUOP_FUNCT;
        end
        EXECI: begin
          bus.alu_src_a = SRCA_RS1;
          bus.alu_src_b = SRCB_IMM;
          w_alu_op      = ALUOP_FUNCT;
        end
        ALUWB: begin
          bus.result_src = RES_ALUOUT;
          bus.reg_write  = 1'b1;
        end
        BEQ: begin
          bus.alu_src_a  = SRCA_RS1;
          bus.alu_src_b  = SRCB_RS2;
          bus.result_src = RES_ALUOUT;
          bus.pc_write   = bus.zero;
          w_alu_op       = ALUOP_SUB;
        end
        JAL: begin
          bus.alu_src_a  = SRCA_OLDPC;
          bus.alu_src_b  = SRCB_FOUR;
          bus.result_src = RES_ALUOUT;
          bus.pc_write   = 1'b1;
        end
        FAULT:   bus.illegal = 1'b1;
        default: bus.illegal = 1'b1;
      endcase
    end
  end

  alu_decoder u_alu_decoder (
    .i_alu_op      (w_alu_op),
    .i_funct3      (bus.funct3),
    .i_op5         (bus.op[5]),
    .i_funct7b5    (bus.funct7b5),
    .o_alu_control (w_alu_control)
  );

  assign bus.alu_control = w_alu_control;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: each instruction class is
// expanded into a per-cycle list of expected control words and compared.
module tb_multicycle_controller;

  typedef enum int {C_R, C_I, C_LW, C_SW, C_BEQ, C_JAL, C_BAD} cls_t;

  typedef struct packed {
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] imm_src;
    logic [2:0] alu_control;
    logic       illegal;
  } ctrl_t;

  logic clk = 1'b0;
  logic reset;
  multicycle_controller_if bus ();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int    vectors     = 0;
  int    miscompares = 0;
  ctrl_t exp_q[$];
  logic  mr_q[$];
  logic  zr_q[$];

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] op_of(input cls_t cls);
    case (cls)
      C_R:     return 7'b0110011;
      C_I:     return 7'b0010011;
      C_LW:    return 7'b0000011;
      C_SW:    return 7'b0100011;
      C_BEQ:   return 7'b1100011;
      C_JAL:   return 7'b1101111;
      default: return 7'b1111111;
    endcase
  endfunction

  function automatic logic [1:0] imm_ref(input cls_t cls);
    case (cls)
      C_SW:    return 2'b01;
      C_BEQ:   return 2'b10;
      C_JAL:   return 2'b11;
      default: return 2'b00;
    endcase
  endfunction

  // Only register-register ops can subtract via funct7; immediates always add.
  function automatic logic [2:0] alu_ref(input cls_t cls, input logic [2:0] f3, input logic f7b5);
    case (f3)
      3'd0:    return (cls == C_R && f7b5) ? 3'b001 : 3'b000;
      3'd2:    return 3'b101;
      3'd6:    return 3'b011;
      3'd7:    return 3'b010;
      default: return 3'b000;
    endcase
  endfunction

  function automatic ctrl_t blank(input logic [1:0] imm);
    ctrl_t e;
    e = '0;
    e.imm_src = imm;
    return e;
  endfunction

  function automatic ctrl_t sample();
    ctrl_t s;
    s.pc_write    = bus.pc_write;
    s.adr_src     = bus.adr_src;
    s.mem_write   = bus.mem_write;
    s.ir_write    = bus.ir_write;
    s.reg_write   = bus.reg_write;
    s.result_src  = bus.result_src;
    s.alu_src_a   = bus.alu_src_a;
    s.alu_src_b   = bus.alu_src_b;
    s.imm_src     = bus.imm_src;
    s.alu_control = bus.alu_control;
    s.illegal     = bus.illegal;
    return s;
  endfunction

  task automatic push(input ctrl_t e, input logic mr, input logic z);
    exp_q.push_back(e);
    mr_q.push_back(mr);
    zr_q.push_back(z);
  endtask

  task automatic set_instr(input cls_t cls, input logic [2:0] f3, input logic f7b5);
    bus.op       = op_of(cls);
    bus.funct3   = f3;
    bus.funct7b5 = f7b5;
  endtask

  // Reference model: expected control word and driven inputs for every cycle of
  // one instruction. mem_wait is the stall count in MEMREAD/MEMWRITE, or the
  // number of cycles to observe in FAULT for an illegal opcode.
  task automatic build(input cls_t cls, input logic [2:0] f3, input logic f7b5,
                       input int fetch_wait, input int mem_wait, input int zero_force);
    ctrl_t      e;
    logic [1:0] imm;
    logic       z;
    exp_q.delete();
    mr_q.delete();
    zr_q.delete();
    imm = imm_ref(cls);
    e = blank(imm);
    e.alu_src_b  = 2'b10;
    e.result_src = 2'b10;
    for (int i = 0; i < fetch_wait; i++) push(e, 1'b0, rbit());
    e.ir_write = 1'b1;
    e.pc_write = 1'b1;
    push(e, 1'b1, rbit());
    e = blank(imm);
    e.alu_src_a = 2'b01;
    e.alu_src_b = 2'b01;
    push(e, rbit(), rbit());
    case (cls)
      C_R, C_I: begin
        e = blank(imm);
        e.alu_src_a   = 2'b10;
        e.alu_src_b   = (cls == C_I) ? 2'b01 : 2'b00;
        e.alu_control = alu_ref(cls, f3, f7b5);
        push(e, rbit(), rbit());
        e = blank(imm);
        e.reg_write = 1'b1;
        push(e, rbit(), rbit());
      end
      C_LW, C_SW: begin
        e = blank(imm);
        e.alu_src_a = 2'b10;
        e.alu_src_b = 2'b01;
        push(e, rbit(), rbit());
        e = blank(imm);
        e.adr_src   = 1'b1;
        e.mem_write = (cls == C_SW);
        for (int i = 0; i < mem_wait; i++) push(e, 1'b0, rbit());
        push(e, 1'b1, rbit());
        if (cls == C_LW) begin
          e = blank(imm);
          e.reg_write  = 1'b1;
          e.result_src = 2'b01;
          push(e, rbit(), rbit());
        end
      end
      C_BEQ: begin
        z = (zero_force < 0) ? rbit() : 1'(zero_force);
        e = blank(imm);
        e.alu_src_a   = 2'b10;
        e.alu_control = 3'b001;
        e.pc_write    = z;
        push(e, rbit(), z);
      end
      C_JAL: begin
        e = blank(imm);
        e.alu_src_a = 2'b01;
        e.alu_src_b = 2'b10;
        e.pc_write  = 1'b1;
        push(e, rbit(), rbit());
        e = blank(imm);
        e.reg_write = 1'b1;
        push(e, rbit(), rbit());
      end
      default: begin
        e = blank(imm);
        e.illegal = 1'b1;
        for (int i = 0; i < mem_wait; i++) push(e, rbit(), rbit());
      end
    endcase
  endtask

  task automatic test_reset();
    ctrl_t got;
    set_instr(C_R, 3'b000, 1'b0);
    build(C_R, 3'b000, 1'b0, 0, 0, -1);
    for (int i = 0; i < 2; i++) begin
      bus.mem_ready = mr_q[i];
      bus.zero      = zr_q[i];
      #1;
      got = sample();
      vectors++;
      if (got !== exp_q[i]) begin
        miscompares++;
        $display("FAIL reset_pre cycle %0d: got %h, expected %h", i, got, exp_q[i]);
      end
      @(negedge clk);
    end
    reset         = 1'b1;
    bus.mem_ready = 1'b1;
    bus.zero      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      got = sample();
      vectors++;
      if (got !== ctrl_t'('0)) begin
        miscompares++;
        $display("FAIL reset_hold cycle %0d: got %h, expected 0", i, got);
      end
      @(negedge clk);
    end
    reset = 1'b0;
    build(C_R, 3'b000, 1'b0, 0, 0, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      bus.mem_ready = mr_q[i];
      bus.zero      = zr_q[i];
      #1;
      got = sample();
      vectors++;
      if (got !== exp_q[i]) begin
        miscompares++;
        $display("FAIL reset_release cycle %0d: got %h, expected %h", i, got, exp_q[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_add();
    ctrl_t got;
    set_instr(C_R, 3'b000, 1'b0);
    build(C_R, 3'b000, 1'b0, 0, 0, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      bus.mem_ready = mr_q[i];
      bus.zero      = zr_q[i];
      #1;
      got = sample();
      vectors++;
      if (got !== exp_q[i]) begin
        miscompares++;
        $display("FAIL add cycle %0d: got %h, expected %h", i, got, exp_q[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_lw_stall();
    ctrl_t got;
    set_instr(C_LW, 3'b010, 1'b0);
    build(C_LW, 3'b010, 1'b0, 0, 2, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      bus.mem_ready = mr_q[i];
      bus.zero      = zr_q[i];
      #1;
      got = sample();
      vectors++;
      if (got !== exp_q[i]) begin
        miscompares++;
        $display("FAIL lw_stall cycle %0d: got %h, expected %h", i, got, exp_q[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_sw();
    ctrl_t got;
    set_instr(C_SW, 3'b010, 1'b1);
    build(C_SW, 3'b010, 1'b1, 1, 3, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      bus.mem_ready = mr_q[i];
      bus.zero      = zr_q[i];
      #1;
      got = sample();
      vectors++;
      if (got !== exp_q[i]) begin
        miscompares++;
        $display("FAIL sw cycle %0d: got %h, expected %h", i, got, exp_q[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_beq();
    ctrl_t got;
    for (int t = 1; t >= 0; t--) begin
      set_instr(C_BEQ, 3'b000, 1'b0);
      build(C_BEQ, 3'b000, 1'b0, 0, 0, t);
      for (int i = 0; i < exp_q.size(); i++) begin
        bus.mem_ready = mr_q[i];
        bus.zero      = zr_q[i];
        #1;
        got = sample();
        vectors++;
        if (got !== exp_q[i]) begin
          miscompares++;
          $display("FAIL beq_zero%0d cycle %0d: got %h, expected %h", t, i, got, exp_q[i]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_back_to_back();
    ctrl_t      got;
    cls_t       cls;
    logic [2:0] f3;
    logic       f7b5;
    for (int n = 0; n < 40; n++) begin
      cls  = cls_t'($urandom_range(0, 5));
      f3   = 3'($urandom_range(0, 7));
      f7b5 = rbit();
      set_instr(cls, f3, f7b5);
      build(cls, f3, f7b5, $urandom_range(0, 2), $urandom_range(0, 2), -1);
      for (int i = 0; i < exp_q.size(); i++) begin
        bus.mem_ready = mr_q[i];
        bus.zero      = zr_q[i];
        #1;
        got = sample();
        vectors++;
        if (got !== exp_q[i]) begin
          miscompares++;
          $display("FAIL b2b instr %0d op %b f3 %0d cycle %0d: got %h, expected %h",
                   n, bus.op, f3, i, got, exp_q[i]);
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic test_fault();
    ctrl_t got;
    set_instr(C_BAD, 3'($urandom_range(0, 7)), rbit());
    build(C_BAD, bus.funct3, bus.funct7b5, 0, 12, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      bus.mem_ready = mr_q[i];
      bus.zero      = zr_q[i];
      #1;
      got = sample();
      vectors++;
      if (got !== exp_q[i]) begin
        miscompares++;
        $display("FAIL fault cycle %0d: got %h, expected %h", i, got, exp_q[i]);
      end
      @(negedge clk);
    end
    reset = 1'b1;
    #1;
    got = sample();
    vectors++;
    if (got !== ctrl_t'('0)) begin
      miscompares++;
      $display("FAIL fault_reset: got %h, expected 0", got);
    end
    @(negedge clk);
    reset = 1'b0;
    set_instr(C_I, 3'b111, 1'b0);
    build(C_I, 3'b111, 1'b0, 1, 0, -1);
    for (int i = 0; i < exp_q.size(); i++) begin
      bus.mem_ready = mr_q[i];
      bus.zero      = zr_q[i];
      #1;
      got = sample();
      vectors++;
      if (got !== exp_q[i]) begin
        miscompares++;
        $display("FAIL fault_restart cycle %0d: got %h, expected %h", i, got, exp_q[i]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    reset         = 1'b1;
    bus.op        = 7'b0;
    bus.funct3    = 3'b0;
    bus.funct7b5  = 1'b0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    test_reset();
    test_add();
    test_lw_stall();
    test_sw();
    test_beq();
    test_back_to_back();
    test_fault();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
